// File: rtl/iter_alu_pkg.sv
// Shared types for the iterative ALU: operation codes, branch conditions,
// control states and operation-class helpers.
package iter_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_LUI    = 5'd10,
    OP_BR     = 5'd11,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_div(alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// retiring BITS_PER_CYCLE bits per cycle; the sign fix is applied to the final step.
module iter_muldiv_core
  import iter_alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_b;
  logic              r_div, r_rem, r_mulhi, r_neg;

  logic              w_rem, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN-1:0]   w_hi, w_lo;
  logic [XLEN:0]     w_acc;
  logic [2*XLEN-1:0] w_prod, w_qr;

  function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign w_rem   = i_op inside {OP_REM, OP_REMU};
  assign w_a_neg = (i_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && i_a[XLEN-1];
  assign w_b_neg = (i_op inside {OP_MULH, OP_DIV, OP_REM}) && i_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (i_start)       r_cnt <= CW'(N);
    else if (r_cnt != '0)   r_cnt <= r_cnt - CW'(1);
  end

  // Accept edge loads magnitudes; each CALC cycle commits one batch of steps
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_b     <= w_b_mag;
      r_div   <= is_div(i_op);
      r_rem   <= w_rem;
      r_mulhi <= (i_op != OP_MUL);
      r_neg   <= w_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
    end else if (r_cnt != '0) begin
      r_hi <= w_hi;
      r_lo <= w_lo;
    end
  end

  always_comb begin
    w_hi  = r_hi;
    w_lo  = r_lo;
    w_acc = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_div) begin
        w_acc = {w_hi, w_lo[XLEN-1]};
        w_lo  = {w_lo[XLEN-2:0], 1'b0};
        if (w_acc >= {1'b0, r_b}) begin
          w_acc    = w_acc - {1'b0, r_b};
          w_lo[0]  = 1'b1;
        end
        w_hi = w_acc[XLEN-1:0];
      end else begin
        w_acc = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
        w_lo  = {w_acc[0], w_lo[XLEN-1:1]};
        w_hi  = w_acc[XLEN:1];
      end
    end
  end

  assign w_prod = sign_fix({w_hi, w_lo}, r_neg);
  assign w_qr   = sign_fix({{XLEN{1'b0}}, (r_rem ? w_hi : w_lo)}, r_neg);
  assign o_res  = r_div ? w_qr[XLEN-1:0]
                        : (r_mulhi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);
  assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/iter_alu.sv
// EX-stage ALU: registered single-cycle ops and branch compares, plus an
// iterative mul/div engine behind a valid/ready handshake.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            src_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      br_funct3,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e                 r_state, w_state_nx;
  logic                   r_out_valid, r_zero;
  logic [XLEN-1:0]        r_result;

  alu_op_e                w_op;
  logic [XLEN-1:0]        w_a, w_b, w_res, w_core_res;
  logic signed [XLEN-1:0] w_a_s, w_b_s;
  logic [SW-1:0]          w_sh;
  logic                   w_lt, w_ltu, w_eq, w_zero;
  logic                   w_dz, w_ovf, w_accept, w_start, w_core_done;

  assign w_op  = alu_op_e'(op);
  assign w_a   = rs1;
  assign w_b   = src_sel ? imm : rs2;
  assign w_a_s = w_a;
  assign w_b_s = w_b;
  assign w_sh  = w_b[SW-1:0];
  assign w_lt  = w_a_s < w_b_s;
  assign w_ltu = w_a < w_b;
  assign w_eq  = w_a == w_b;

  // Divide-by-zero and signed overflow finish on the single-cycle path
  assign w_dz     = is_div(w_op) && (w_b == '0);
  assign w_ovf    = (w_op inside {OP_DIV, OP_REM}) && (w_a == MOST_NEG) && (w_b == '1);
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_start  = w_accept && is_multicycle(w_op) && !w_dz && !w_ovf;

  always_comb begin
    w_res  = '0;
    w_zero = 1'b0;
    case (w_op)
      OP_ADD:  w_res = w_a + w_b;
      OP_SUB:  w_res = w_a - w_b;
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_SLL:  w_res = w_a << w_sh;
      OP_SRL:  w_res = w_a >> w_sh;
      OP_SRA:  w_res = w_a_s >>> w_sh;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, w_lt};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, w_ltu};
      OP_LUI:  w_res = w_b << 12;
      OP_BR: begin
        w_res = w_a - w_b;
        case (br_funct3)
          BR_EQ:   w_zero = w_eq;
          BR_NE:   w_zero = !w_eq;
          BR_LT:   w_zero = w_lt;
          BR_GE:   w_zero = !w_lt;
          BR_LTU:  w_zero = w_ltu;
          BR_GEU:  w_zero = !w_ltu;
          default: w_zero = 1'b0;
        endcase
      end
      OP_DIV, OP_DIVU: w_res = w_dz ? '1 : MOST_NEG;
      OP_REM, OP_REMU: w_res = w_dz ? w_a : '0;
      default: w_res = '0;
    endcase
  end

  iter_muldiv_core #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_op    (w_op),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_done  (w_core_done),
    .o_res   (w_core_res)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_CALC;
      S_CALC:  if (w_core_done) w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output stage: result/zero held until the next out_valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_core_done && r_state == S_CALC) begin
        r_out_valid <= 1'b1;
        r_result    <= w_core_res;
        r_zero      <= 1'b0;
      end else if (w_accept && !w_start) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_zero      <= w_zero;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: one instance at 1 bit/cycle and one at 4 bits/cycle
// share the stimulus; latency and results are checked on both.
module tb_iter_alu;
  import iter_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, src_sel;
  logic [4:0]  op;
  logic [31:0] rs1, rs2, imm;
  logic [2:0]  br_funct3;

  logic        rdy1, ov1, z1, rdy4, ov4, z4;
  logic [31:0] res1, res4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iter_alu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .src_sel(src_sel), .rs1(rs1), .rs2(rs2), .imm(imm), .br_funct3(br_funct3),
    .out_valid(ov1), .result(res1), .zero(z1));

  iter_alu #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .op(op),
    .src_sel(src_sel), .rs1(rs1), .rs2(rs2), .imm(imm), .br_funct3(br_funct3),
    .out_valid(ov4), .result(res4), .zero(z4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input alu_op_e o, input logic [31:0] a, input logic [31:0] b,
                     input logic sel, input logic [2:0] f3, input logic [31:0] er,
                     input logic ez, input int l1, input int l4, input string tag);
    int lat1, lat4, busy_rdy;
    logic [31:0] r1, r4;
    logic zz1, zz4;
    lat1 = -1; lat4 = -1; busy_rdy = 0;
    r1 = 'x; r4 = 'x; zz1 = 1'bx; zz4 = 1'bx;
    op = o; rs1 = a; src_sel = sel; br_funct3 = f3;
    rs2 = sel ? 32'hDEAD_BEEF : b;
    imm = sel ? b : 32'hDEAD_BEEF;
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, {31'b0, rdy1}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = OP_ADD; rs1 = ~a; rs2 = ~b; imm = ~b;
    for (int c = 1; c <= 60 && (lat1 < 0 || lat4 < 0); c++) begin
      if (lat1 < 0 && rdy1) busy_rdy++;
      if (lat1 < 0 && ov1) begin lat1 = c; r1 = res1; zz1 = z1; end
      if (lat4 < 0 && ov4) begin lat4 = c; r4 = res4; zz4 = z4; end
      @(posedge clk); #1;
    end
    chk({tag, ".lat1"}, 32'(lat1), 32'(l1));
    chk({tag, ".res1"}, r1, er);
    chk({tag, ".zero1"}, {31'b0, zz1}, {31'b0, ez});
    chk({tag, ".lat4"}, 32'(lat4), 32'(l4));
    chk({tag, ".res4"}, r4, er);
    chk({tag, ".zero4"}, {31'b0, zz4}, {31'b0, ez});
    if (l1 > 1) chk({tag, ".busy_ready"}, 32'(busy_rdy), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; op = OP_ADD; src_sel = 1'b0;
    rs1 = '0; rs2 = '0; imm = '0; br_funct3 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", {31'b0, rdy1}, 32'd1);
    chk("reset.out_valid", {31'b0, ov1}, 32'd0);
    chk("reset.result", res1, 32'd0);
    chk("reset.zero", {31'b0, z1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-cycle accepts
    op = OP_ADD; rs1 = 32'd5; imm = 32'hFFFF_FFFF; rs2 = 32'd0; src_sel = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("add.out_valid", {31'b0, ov1}, 32'd1);
    chk("add.result", res1, 32'd4);
    chk("add.zero", {31'b0, z1}, 32'd0);
    chk("add.in_ready", {31'b0, rdy1}, 32'd1);
    op = OP_SUB; rs1 = 32'd10; rs2 = 32'd3; src_sel = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sub.out_valid", {31'b0, ov1}, 32'd1);
    chk("sub.result", res1, 32'd7);
    @(posedge clk); #1;
    chk("sub.pulse", {31'b0, ov1}, 32'd0);

    run(OP_BR, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b110, 32'hFFFF_FFFE, 1'b0, 1, 1, "br_ltu");
    run(OP_BR, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b100, 32'hFFFF_FFFE, 1'b1, 1, 1, "br_lt");
    run(OP_BR, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b111, 32'hFFFF_FFFE, 1'b1, 1, 1, "br_geu");
    run(OP_BR, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b000, 32'hFFFF_FFFE, 1'b0, 1, 1, "br_eq");
    run(OP_BR, 32'd9, 32'd9, 1'b0, 3'b010, 32'd0, 1'b0, 1, 1, "br_010");

    run(OP_MUL,    32'hFFFF_FFFD, 32'd7, 1'b0, 3'b0, 32'hFFFF_FFEB, 1'b0, 33, 9, "mul");
    run(OP_MULHU,  32'hFFFF_FFFD, 32'd7, 1'b0, 3'b0, 32'h0000_0006, 1'b0, 33, 9, "mulhu");
    run(OP_MULH,   32'hFFFF_FFFD, 32'd7, 1'b0, 3'b0, 32'hFFFF_FFFF, 1'b0, 33, 9, "mulh");
    run(OP_MULHSU, 32'hFFFF_FFFD, 32'd7, 1'b0, 3'b0, 32'hFFFF_FFFF, 1'b0, 33, 9, "mulhsu");

    run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 3'b0, 32'hFFFF_FFFD, 1'b0, 33, 9, "div");
    run(OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0, 3'b0, 32'hFFFF_FFFF, 1'b0, 33, 9, "rem");
    run(OP_DIV,  32'd7, 32'hFFFF_FFFE, 1'b0, 3'b0, 32'hFFFF_FFFD, 1'b0, 33, 9, "div_negb");
    run(OP_REM,  32'd7, 32'hFFFF_FFFE, 1'b0, 3'b0, 32'd1, 1'b0, 33, 9, "rem_negb");
    run(OP_DIVU, 32'd100, 32'd7, 1'b0, 3'b0, 32'd14, 1'b0, 33, 9, "divu");
    run(OP_REMU, 32'd100, 32'd7, 1'b0, 3'b0, 32'd2, 1'b0, 33, 9, "remu");
    run(OP_DIVU, 32'd7, 32'd0, 1'b0, 3'b0, 32'hFFFF_FFFF, 1'b0, 1, 1, "divu_zero");
    run(OP_REMU, 32'd7, 32'd0, 1'b0, 3'b0, 32'd7, 1'b0, 1, 1, "remu_zero");
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'b0, 32'h8000_0000, 1'b0, 1, 1, "div_ovf");
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'b0, 32'd0, 1'b0, 1, 1, "rem_ovf");

    run(OP_SRA,  32'h8000_0000, 32'h24, 1'b0, 3'b0, 32'hF800_0000, 1'b0, 1, 1, "sra");
    run(OP_SRL,  32'h8000_0000, 32'h24, 1'b0, 3'b0, 32'h0800_0000, 1'b0, 1, 1, "srl");
    run(OP_LUI,  32'd0, 32'h0001_2345, 1'b1, 3'b0, 32'h1234_5000, 1'b0, 1, 1, "lui");
    run(OP_SLT,  32'hFFFF_FFFF, 32'd1, 1'b0, 3'b0, 32'd1, 1'b0, 1, 1, "slt");
    run(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b0, 32'd0, 1'b0, 1, 1, "sltu");
    run(alu_op_e'(5'd31), 32'd3, 32'd4, 1'b0, 3'b000, 32'd0, 1'b0, 1, 1, "illegal");

    // Reset in the middle of a long divide
    op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; src_sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    seen = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.in_ready", {31'b0, rdy1}, 32'd1);
    chk("abort.result1", res1, 32'd0);
    chk("abort.result4", res4, 32'd0);
    repeat (40) begin
      if (ov1) seen++;
      @(posedge clk); #1;
    end
    chk("abort.no_out_valid", 32'(seen), 32'd0);
    run(OP_ADD, 32'd1, 32'd2, 1'b0, 3'b0, 32'd3, 1'b0, 1, 1, "add_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
